command_sequencer: RTL and testbench
====================================

COMMAND_SEQUENCER -- requirements
Module: command_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, command-memory address width.
REQ-002 SHALL have parameter COORD_W, default 14, coordinate width in two's complement.
REQ-003 SHALL have port clk  in  1  sole clock, all state on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle request to run the program from address 0.
REQ-006 SHALL have port mem_addr  out  ADDR_W  command-memory read address.
REQ-007 SHALL have port mem_rd  out  1  read strobe.
REQ-008 SHALL have port mem_rdata  in  32  command word: [31:28] cmd, [27:14] x, [13:0] y.
REQ-009 SHALL have ports move_valid out 1 / move_ready in 1, the move handshake.
REQ-010 SHALL have ports move_x / move_y  out  COORD_W  absolute move target.
REQ-011 SHALL have port move_linear  out  1  1 = G01, 0 = G00.
REQ-012 SHALL have ports tool_req out 1 / tool_ack in 1 / tool_num out 4, the tool-change handshake.
REQ-013 SHALL have ports pen_up, inches, relative  out  1 each, the modal state.
REQ-014 SHALL have ports busy, done, error  out  1 each, the run status.

Function
REQ-015 SHALL decode cmd as G00=0, G01=1, G20=2, G21=3, G90=4, G91=5, M2=6, M6=7, M72=8; codes 9-15 are illegal.
REQ-016 SHALL implement states IDLE, FETCH, WAIT, EXEC, MOVE, TOOL, DONE, ERR.
REQ-017 SHALL transition IDLE/DONE/ERR -> FETCH on start: mem_addr=0, inches=1, relative=0, pen_up=0, done=0, error=0; current position retained.
REQ-018 SHALL ignore start in FETCH, WAIT, EXEC, MOVE and TOOL.
REQ-019 SHALL, in FETCH, assert mem_rd for exactly one cycle, then go to WAIT; memory read latency is fixed at 1 cycle.
REQ-020 SHALL, in WAIT, register mem_rdata, then go to EXEC; a non-move command therefore costs 3 cycles.
REQ-021 SHALL handle G20/G21/G90/G91 in EXEC by setting inches=1/inches=0/relative=0/relative=1, then advance.
REQ-022 SHALL handle M72 in EXEC by toggling pen_up, then advance.
REQ-023 SHALL, for G00/G01, compute the target: absolute = (x, y); relative = position + (x, y), modulo 2^COORD_W (wrap, no saturation). It SHALL then enter MOVE with move_valid=1.
REQ-024 SHALL hold move_valid, move_x, move_y and move_linear stable in MOVE until a cycle with move_ready=1. On that cycle it SHALL update position to the target, drop move_valid next cycle and advance.
REQ-025 SHALL ignore move_ready while move_valid=0.
REQ-026 SHALL, for M6, set tool_num = x[3:0] and enter TOOL with tool_req=1, held until tool_ack=1, then drop tool_req and advance.
REQ-027 SHALL, for M2, enter DONE with done=1.
REQ-028 SHALL, for an illegal cmd, enter ERR with error=1; mem_addr frozen at the offending address.
REQ-029 SHALL define advance as mem_addr+1 and FETCH. If mem_addr = 2^ADDR_W-1 and the command was not M2, it SHALL go to ERR instead (no wrap).
REQ-030 SHALL drive busy=1 in every state except IDLE, DONE and ERR.
REQ-031 SHALL pass units through unconverted; inches only annotates downstream scaling.

Reset
REQ-032 SHALL, on reset asserted at any time including mid-MOVE/TOOL, immediately force IDLE, mem_addr=0, mem_rd=0, move_valid=0, move_x=move_y=0, move_linear=0, tool_req=0, tool_num=0, pen_up=0, inches=1, relative=0, position=0, busy=done=error=0.
REQ-033 SHALL take no action in the first clk edge after reset deasserts unless start=1.

Structure
REQ-034 SHALL take the cmd enum, the command-word field offsets and the COORD_W default from shared package scara_pkg.
REQ-035 SHALL place target arithmetic in one combinational sub-module target_calc (inputs: position, x, y, relative; outputs: target x/y).

Verification
REQ-036 Bench SHALL cover: program {G21, G90, G01 x=100 y=200, M2}, move_ready=1 -> inches=0, one move (100,200,linear=1), done=1 after memory address 3.
REQ-037 Bench SHALL cover: position (100,200), {G91, G00 x=-50 y=16383, M2} -> move (50,199), move_linear=0.
REQ-038 Bench SHALL cover: move_ready held 0 for 10 cycles during MOVE -> move_valid and payload unchanged for all 10 cycles; exactly one position update.
REQ-039 Bench SHALL cover: {M6 x=5, M72, M72, M2}, tool_ack after 4 cycles -> tool_num=5, tool_req high 4 cycles, pen_up ends 0.
REQ-040 Bench SHALL cover: cmd=12 at address 2 -> error=1, mem_addr=2, busy=0; a later start restarts from address 0.
REQ-041 Bench SHALL cover: reset asserted mid-MOVE -> outputs at reset values asynchronously; memory with no M2 -> ERR after address 255.

Source files
------------

// File: rtl/scara_pkg.sv
// rtl/scara_pkg.sv - shared command encodings, word layout and FSM states
package scara_pkg;

  localparam int COORD_W_DEFAULT = 14;
  localparam int FIELD_W         = 14;
  localparam int CMD_LSB         = 28;
  localparam int X_LSB           = 14;
  localparam int Y_LSB           = 0;

  typedef enum logic [3:0] {
    CMD_G00 = 4'd0,
    CMD_G01 = 4'd1,
    CMD_G20 = 4'd2,
    CMD_G21 = 4'd3,
    CMD_G90 = 4'd4,
    CMD_G91 = 4'd5,
    CMD_M2  = 4'd6,
    CMD_M6  = 4'd7,
    CMD_M72 = 4'd8
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_EXEC,
    ST_MOVE,
    ST_TOOL,
    ST_DONE,
    ST_ERR
  } state_e;

  function automatic logic [3:0] word_cmd(input logic [31:0] w);
    return w[CMD_LSB +: 4];
  endfunction

  function automatic logic [FIELD_W-1:0] word_x(input logic [31:0] w);
    return w[X_LSB +: FIELD_W];
  endfunction

  function automatic logic [FIELD_W-1:0] word_y(input logic [31:0] w);
    return w[Y_LSB +: FIELD_W];
  endfunction

endpackage

// File: rtl/target_calc.sv
// rtl/target_calc.sv - absolute or relative move target, wrapping two's complement
module target_calc
  import scara_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT
) (
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [FIELD_W-1:0] x,
  input  logic [FIELD_W-1:0] y,
  input  logic               relative,
  output logic [COORD_W-1:0] target_x,
  output logic [COORD_W-1:0] target_y
);

  // Command fields are signed; extend them to the coordinate width.
  logic [COORD_W-1:0] ext_x;
  logic [COORD_W-1:0] ext_y;
  assign ext_x = COORD_W'($signed(x));
  assign ext_y = COORD_W'($signed(y));

  // Relative targets simply wrap modulo 2^COORD_W.
  always_comb begin
    target_x = ext_x;
    target_y = ext_y;
    if (relative) begin
      target_x = pos_x + ext_x;
      target_y = pos_y + ext_y;
    end
  end

endmodule

// File: rtl/command_sequencer.sv
// rtl/command_sequencer.sv - fetches command words and drives move/tool handshakes
module command_sequencer
  import scara_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int COORD_W = COORD_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [31:0]        mem_rdata,
  output logic               move_valid,
  input  logic               move_ready,
  output logic [COORD_W-1:0] move_x,
  output logic [COORD_W-1:0] move_y,
  output logic               move_linear,
  output logic               tool_req,
  input  logic               tool_ack,
  output logic [3:0]         tool_num,
  output logic               pen_up,
  output logic               inches,
  output logic               relative,
  output logic               busy,
  output logic               done,
  output logic               error
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        word_q, word_d;
  logic [COORD_W-1:0] mvx_q, mvx_d, mvy_q, mvy_d;
  logic [COORD_W-1:0] posx_q, posx_d, posy_q, posy_d;
  logic               lin_q, lin_d;
  logic [3:0]         tool_num_q, tool_num_d;
  logic               pen_q, pen_d, inch_q, inch_d, rel_q, rel_d;

  cmd_e               cmd;
  logic [FIELD_W-1:0] fld_x, fld_y;
  logic [COORD_W-1:0] tgt_x, tgt_y;
  logic               adv;

  assign cmd   = cmd_e'(word_cmd(word_q));
  assign fld_x = word_x(word_q);
  assign fld_y = word_y(word_q);

  target_calc #(.COORD_W(COORD_W)) u_target (
    .pos_x    (posx_q),
    .pos_y    (posy_q),
    .x        (fld_x),
    .y        (fld_y),
    .relative (rel_q),
    .target_x (tgt_x),
    .target_y (tgt_y)
  );

  // Next-state logic; 'adv' moves to the next word, or errors at the top of memory.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_d     = word_q;
    mvx_d      = mvx_q;
    mvy_d      = mvy_q;
    lin_d      = lin_q;
    posx_d     = posx_q;
    posy_d     = posy_q;
    tool_num_d = tool_num_q;
    pen_d      = pen_q;
    inch_d     = inch_q;
    rel_d      = rel_q;
    adv        = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_FETCH;
          addr_d  = '0;
          inch_d  = 1'b1;
          rel_d   = 1'b0;
          pen_d   = 1'b0;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        word_d  = mem_rdata;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (cmd)
          CMD_G20: begin inch_d = 1'b1; adv = 1'b1; end
          CMD_G21: begin inch_d = 1'b0; adv = 1'b1; end
          CMD_G90: begin rel_d  = 1'b0; adv = 1'b1; end
          CMD_G91: begin rel_d  = 1'b1; adv = 1'b1; end
          CMD_M72: begin pen_d  = ~pen_q; adv = 1'b1; end
          CMD_G00, CMD_G01: begin
            mvx_d   = tgt_x;
            mvy_d   = tgt_y;
            lin_d   = (cmd == CMD_G01);
            state_d = ST_MOVE;
          end
          CMD_M6: begin
            tool_num_d = fld_x[3:0];
            state_d    = ST_TOOL;
          end
          CMD_M2:  state_d = ST_DONE;
          default: state_d = ST_ERR;
        endcase
      end
      ST_MOVE: begin
        if (move_ready) begin
          posx_d = mvx_q;
          posy_d = mvy_q;
          adv    = 1'b1;
        end
      end
      ST_TOOL: begin
        if (tool_ack) adv = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (adv) begin
      if (addr_q == '1) begin
        state_d = ST_ERR;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = ST_FETCH;
      end
    end
  end

  // State register; reset forces every output to its idle value at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      word_q     <= '0;
      mvx_q      <= '0;
      mvy_q      <= '0;
      lin_q      <= 1'b0;
      posx_q     <= '0;
      posy_q     <= '0;
      tool_num_q <= '0;
      pen_q      <= 1'b0;
      inch_q     <= 1'b1;
      rel_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      mvx_q      <= mvx_d;
      mvy_q      <= mvy_d;
      lin_q      <= lin_d;
      posx_q     <= posx_d;
      posy_q     <= posy_d;
      tool_num_q <= tool_num_d;
      pen_q      <= pen_d;
      inch_q     <= inch_d;
      rel_q      <= rel_d;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_rd      = (state_q == ST_FETCH);
  assign move_valid  = (state_q == ST_MOVE);
  assign move_x      = mvx_q;
  assign move_y      = mvy_q;
  assign move_linear = lin_q;
  assign tool_req    = (state_q == ST_TOOL);
  assign tool_num    = tool_num_q;
  assign pen_up      = pen_q;
  assign inches      = inch_q;
  assign relative    = rel_q;
  assign busy        = !(state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
  assign done        = (state_q == ST_DONE);
  assign error       = (state_q == ST_ERR);

endmodule

// File: tb/tb_command_sequencer.sv
// tb/tb_command_sequencer.sv - directed vectors and sequences for command_sequencer
module tb_command_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, move_ready, tool_ack;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        move_valid, move_linear, tool_req;
  logic [13:0] move_x, move_y;
  logic [3:0]  tool_num;
  logic        pen_up, inches, relative, busy, done, error;

  logic [31:0] mem [256];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          mv_cnt = 0;
  int          tool_cnt = 0;
  logic [13:0] mv_x, mv_y;
  logic        mv_lin;

  always #5 clk = ~clk;

  command_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .move_valid(move_valid), .move_ready(move_ready),
    .move_x(move_x), .move_y(move_y), .move_linear(move_linear),
    .tool_req(tool_req), .tool_ack(tool_ack), .tool_num(tool_num),
    .pen_up(pen_up), .inches(inches), .relative(relative),
    .busy(busy), .done(done), .error(error)
  );

  // One-cycle-latency command memory.
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  // Record accepted moves and cycles spent requesting a tool.
  always @(posedge clk) begin
    if (move_valid && move_ready) begin
      mv_cnt = mv_cnt + 1;
      mv_x   = move_x;
      mv_y   = move_y;
      mv_lin = move_linear;
    end
    if (tool_req) tool_cnt = tool_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] w(input logic [3:0] c, input int x, input int y);
    logic [13:0] xf, yf;
    xf = 14'(x);
    yf = 14'(y);
    return {c, xf, yf};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic fill_mem(input logic [31:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic load4(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    fill_mem(w(4'd15, 0, 0));
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string nm);
    int i;
    i = 0;
    while (busy && i < bound) begin
      tick();
      i++;
    end
    check({nm, "_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic run(input int bound, input string nm);
    pulse_start();
    wait_idle(bound, nm);
  endtask

  typedef struct {
    logic [31:0] word;
    logic        e_inch, e_rel, e_pen, e_done, e_err;
    logic [7:0]  e_addr;
  } vec_t;

  vec_t tbl[7];
  int   base;

  initial begin
    tbl[0] = '{w(4'd2, 0, 0), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[1] = '{w(4'd3, 0, 0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[2] = '{w(4'd5, 0, 0), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[3] = '{w(4'd4, 0, 0), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[4] = '{w(4'd8, 0, 0), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[5] = '{w(4'd9, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[6] = '{w(4'd15, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};

    reset = 1'b1; start = 1'b0; move_ready = 1'b1; tool_ack = 1'b0;
    fill_mem(w(4'd6, 0, 0));
    tick(); tick();
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_inches", 32'(inches), 1);
    check("rst_tool_num", 32'(tool_num), 0);
    reset = 1'b0;
    tick();
    check("post_rst_idle", 32'(busy), 0);
    check("post_rst_rd", 32'(mem_rd), 0);

    // Single modal/illegal command followed by M2.
    for (int i = 0; i < 7; i++) begin
      load4(tbl[i].word, w(4'd6, 0, 0), w(4'd6, 0, 0), w(4'd6, 0, 0));
      run(50, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_inches", i), 32'(inches), 32'(tbl[i].e_inch));
      check($sformatf("tbl%0d_relative", i), 32'(relative), 32'(tbl[i].e_rel));
      check($sformatf("tbl%0d_pen_up", i), 32'(pen_up), 32'(tbl[i].e_pen));
      check($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].e_done));
      check($sformatf("tbl%0d_error", i), 32'(error), 32'(tbl[i].e_err));
      check($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
    end

    // G21, G90, G01 (100,200), M2.
    base = mv_cnt;
    load4(w(4'd3, 0, 0), w(4'd4, 0, 0), w(4'd1, 100, 200), w(4'd6, 0, 0));
    run(100, "prog1");
    check("prog1_inches", 32'(inches), 0);
    check("prog1_moves", 32'(mv_cnt - base), 1);
    check("prog1_mv_x", 32'(mv_x), 100);
    check("prog1_mv_y", 32'(mv_y), 200);
    check("prog1_mv_lin", 32'(mv_lin), 1);
    check("prog1_done", 32'(done), 1);
    check("prog1_addr", 32'(mem_addr), 3);

    // Relative from (100,200): G91, G00 (-50,16383 = -1), M2.
    load4(w(4'd5, 0, 0), w(4'd0, -50, 16383), w(4'd6, 0, 0), w(4'd6, 0, 0));
    run(100, "prog2");
    check("prog2_mv_x", 32'(mv_x), 50);
    check("prog2_mv_y", 32'(mv_y), 199);
    check("prog2_mv_lin", 32'(mv_lin), 0);

    // Back-pressure: move_ready low for 10 cycles, start pulse ignored meanwhile.
    move_ready = 1'b0;
    base = mv_cnt;
    load4(w(4'd4, 0, 0), w(4'd1, 7, 9), w(4'd6, 0, 0), w(4'd6, 0, 0));
    pulse_start();
    for (int i = 0; i < 20 && !move_valid; i++) tick();
    check("hold_enter", 32'(move_valid), 1);
    for (int k = 0; k < 10; k++) begin
      start = (k == 4);
      tick();
      check("hold_valid", 32'(move_valid), 1);
      check("hold_payload", {15'd0, move_linear, move_x[7:0], move_y[7:0]}, {15'd0, 1'b1, 8'd7, 8'd9});
      check("hold_addr", 32'(mem_addr), 1);
    end
    start = 1'b0;
    move_ready = 1'b1;
    wait_idle(50, "hold");
    check("hold_moves", 32'(mv_cnt - base), 1);
    load4(w(4'd5, 0, 0), w(4'd0, 0, 0), w(4'd6, 0, 0), w(4'd6, 0, 0));
    run(100, "hold_pos");
    check("hold_pos_x", 32'(mv_x), 7);
    check("hold_pos_y", 32'(mv_y), 9);

    // Tool change: ack after tool_req has been high 4 cycles, then two pen toggles.
    base = tool_cnt;
    load4(w(4'd7, 5, 0), w(4'd8, 0, 0), w(4'd8, 0, 0), w(4'd6, 0, 0));
    pulse_start();
    for (int i = 0; i < 20 && !tool_req; i++) tick();
    check("tool_req_rise", 32'(tool_req), 1);
    check("tool_num", 32'(tool_num), 5);
    tick(); tick(); tick();
    tool_ack = 1'b1;
    tick();
    tool_ack = 1'b0;
    check("tool_req_drop", 32'(tool_req), 0);
    wait_idle(50, "tool");
    check("tool_cycles", 32'(tool_cnt - base), 4);
    check("tool_pen_up", 32'(pen_up), 0);
    check("tool_done", 32'(done), 1);

    // Illegal command at address 2, then restart from 0.
    load4(w(4'd2, 0, 0), w(4'd2, 0, 0), w(4'd12, 0, 0), w(4'd6, 0, 0));
    run(50, "ill");
    check("ill_error", 32'(error), 1);
    check("ill_addr", 32'(mem_addr), 2);
    check("ill_busy", 32'(busy), 0);
    check("ill_done", 32'(done), 0);
    pulse_start();
    check("restart_addr", 32'(mem_addr), 0);
    check("restart_rd", 32'(mem_rd), 1);
    check("restart_error", 32'(error), 0);
    wait_idle(50, "restart");
    check("restart_again_addr", 32'(mem_addr), 2);

    // Reset in the middle of a held move.
    move_ready = 1'b0;
    load4(w(4'd1, 3, 4), w(4'd6, 0, 0), w(4'd6, 0, 0), w(4'd6, 0, 0));
    pulse_start();
    for (int i = 0; i < 20 && !move_valid; i++) tick();
    check("mid_move_valid", 32'(move_valid), 1);
    #2 reset = 1'b1;
    #1;
    check("async_valid", 32'(move_valid), 0);
    check("async_xy", {18'd0, move_x}, 0);
    check("async_y", {18'd0, move_y}, 0);
    check("async_lin", 32'(move_linear), 0);
    check("async_busy", 32'(busy), 0);
    check("async_inches", 32'(inches), 1);
    tick();
    reset = 1'b0;
    move_ready = 1'b1;
    tick();
    check("after_rst_idle", 32'(busy), 0);

    // Position cleared by reset; then a wrapping relative move.
    load4(w(4'd5, 0, 0), w(4'd0, 5, 6), w(4'd6, 0, 0), w(4'd6, 0, 0));
    run(100, "pos0");
    check("pos0_x", 32'(mv_x), 5);
    check("pos0_y", 32'(mv_y), 6);
    load4(w(4'd5, 0, 0), w(4'd0, 8190, 0), w(4'd6, 0, 0), w(4'd6, 0, 0));
    run(100, "wrap");
    check("wrap_x", 32'(mv_x), 8195);
    check("wrap_y", 32'(mv_y), 6);

    // No M2 anywhere: runs off the end of memory.
    fill_mem(w(4'd2, 0, 0));
    run(1500, "end_mem");
    check("end_error", 32'(error), 1);
    check("end_addr", 32'(mem_addr), 255);
    check("end_done", 32'(done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
